// File: rtl/branch_trace_fifo.sv
// branch_trace_fifo: buffers branch-target addresses from the CPU trace port
// in a synchronous circular FIFO and presents them to the ROP detector over an
// Empty/RdEn/Data interface. The trace port cannot stall, so writes into a full
// FIFO are dropped and reported through a sticky overflow flag.
//
// Build option: define TRACE_FILTER_EN to enqueue only addresses inside the
// inclusive trampoline window [iTRAMPOLINE_START, iTRAMPOLINE_END]. Without it
// every valid trace address is enqueued and the trampoline ports are unused.
module branch_trace_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 32,
  parameter int AFULL_THRESH = 12
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iTrace_Valid,
  input  logic [DATA_W-1:0] iTrace_Addr,
  input  logic [31:0]       iTRAMPOLINE_START,
  input  logic [31:0]       iTRAMPOLINE_END,
  input  logic              iRdEn,
  input  logic              iClrErr,
  output logic              oEmpty,
  output logic              oFull,
  output logic              oAlmostFull,
  output logic [ADDR_W:0]   oCount,
  output logic [DATA_W-1:0] oData,
  output logic              oOverflow,
  output logic              oUnderflow
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_THRESH);

  // Storage is deliberately left out of reset; pointers and count define validity.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              afull_q, afull_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic pass_filter_s;
  logic wr_req_s;
  logic rd_ok_s;
  logic wr_acc_s;
  logic wr_drop_s;
  logic rd_empty_s;

`ifdef TRACE_FILTER_EN
  // Window check: unsigned, both bounds inclusive.
  always_comb begin
    pass_filter_s = 1'b0;
    if ((32'(iTrace_Addr) >= iTRAMPOLINE_START) && (32'(iTrace_Addr) <= iTRAMPOLINE_END)) begin
      pass_filter_s = 1'b1;
    end else begin
      pass_filter_s = 1'b0;
    end
  end
`else
  // Trampoline bounds only matter to the filter; fold them into a sink.
  logic unused_trampoline_s;
  assign unused_trampoline_s = ^{iTRAMPOLINE_START, iTRAMPOLINE_END};

  // Without the filter every valid trace address is a write request.
  always_comb begin
    pass_filter_s = 1'b1;
  end
`endif

  // Request qualification: a full FIFO still accepts a write when a read frees a slot.
  always_comb begin
    wr_req_s   = iTrace_Valid && pass_filter_s;
    rd_ok_s    = iRdEn && (count_q != {(ADDR_W+1){1'b0}});
    rd_empty_s = iRdEn && (count_q == {(ADDR_W+1){1'b0}});
    wr_acc_s   = wr_req_s && ((count_q < DEPTH_CNT) || rd_ok_s);
    wr_drop_s  = wr_req_s && !wr_acc_s;
  end

  // Next-state for pointers, count, registered flags, read data and sticky errors.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    data_d      = data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_ok_s) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      data_d   = mem_q[rd_ptr_q];
    end else if (iRdEn) begin
      // Empty read returns zero, which the detector treats as a harmless direct jump.
      rd_ptr_d = rd_ptr_q;
      data_d   = {DATA_W{1'b0}};
    end else begin
      rd_ptr_d = rd_ptr_q;
      data_d   = data_q;
    end

    count_d = count_q + (ADDR_W+1)'(wr_acc_s) - (ADDR_W+1)'(rd_ok_s);

    // Flags come from the next count so they line up with oCount.
    empty_d = (count_d == {(ADDR_W+1){1'b0}});
    full_d  = (count_d == DEPTH_CNT);
    afull_d = (count_d >= AFULL_CNT);

    // A new error in the same cycle as a clear wins.
    if (wr_drop_s) begin
      overflow_d = 1'b1;
    end else if (iClrErr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (rd_empty_s) begin
      underflow_d = 1'b1;
    end else if (iClrErr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr_q    <= {ADDR_W{1'b0}};
      rd_ptr_q    <= {ADDR_W{1'b0}};
      count_q     <= {(ADDR_W+1){1'b0}};
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      data_q      <= {DATA_W{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      data_q      <= data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write; suppressed during reset so a reset cycle never leaves a stale entry.
  always_ff @(posedge iClk) begin
    if (!iRst && wr_acc_s) begin
      mem_q[wr_ptr_q] <= iTrace_Addr;
    end
  end

  assign oEmpty      = empty_q;
  assign oFull       = full_q;
  assign oAlmostFull = afull_q;
  assign oCount      = count_q;
  assign oData       = data_q;
  assign oOverflow   = overflow_q;
  assign oUnderflow  = underflow_q;

endmodule

// File: tb/tb_branch_trace_fifo.sv
// Directed testbench for branch_trace_fifo: a vector table for the basic
// write/read/underflow path, plus hand sequences for fill/overflow, full
// read+write, wrap-around with a queue model, the trace filter, and reset.
module tb_branch_trace_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        trace_valid;
  logic [31:0] trace_addr;
  logic [31:0] tramp_start;
  logic [31:0] tramp_end;
  logic        rd_en;
  logic        clr_err;
  logic        empty;
  logic        full;
  logic        afull;
  logic [4:0]  count;
  logic [31:0] data;
  logic        ovf;
  logic        unf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_trace_fifo dut (
    .iClk(clk), .iRst(rst), .iTrace_Valid(trace_valid), .iTrace_Addr(trace_addr),
    .iTRAMPOLINE_START(tramp_start), .iTRAMPOLINE_END(tramp_end),
    .iRdEn(rd_en), .iClrErr(clr_err),
    .oEmpty(empty), .oFull(full), .oAlmostFull(afull), .oCount(count),
    .oData(data), .oOverflow(ovf), .oUnderflow(unf)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] addr;
    logic        rd;
    logic        clr;
    logic [4:0]  cnt;
    logic        emp;
    logic        ful;
    logic        af;
    logic [31:0] dat;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample #1 after the edge.
  task automatic cyc(input logic r, input logic v, input logic [31:0] a, input logic rd, input logic clr);
    rst = r; trace_valid = v; trace_addr = a; rd_en = rd; clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [4:0] c, input logic e, input logic f,
                         input logic af, input logic [31:0] d, input logic o, input logic u);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".full"},  32'(full),  32'(f));
    chk({tag, ".afull"}, 32'(afull), 32'(af));
    chk({tag, ".data"},  data, d);
    chk({tag, ".ovf"},   32'(ovf),   32'(o));
    chk({tag, ".unf"},   32'(unf),   32'(u));
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_data;
  logic        w;
  logic        r;
  logic        rok;

  initial begin
    tramp_start = 32'h0000_1000;
    tramp_end   = 32'h0000_10FF;
    rst = 1'b1; trace_valid = 1'b0; trace_addr = 32'h0; rd_en = 1'b0; clr_err = 1'b0;

    //           rst   v     addr          rd    clr   cnt    emp   ful   af    data          ovf   unf
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h1000,     1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h1008,     1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h1004,     1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 32'h1000,     1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 32'h1008,     1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h1004,     1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h10F0,     1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h10F0,     1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h10F0,     1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].rst, vecs[i].v, vecs[i].addr, vecs[i].rd, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].af,
              vecs[i].dat, vecs[i].ovf, vecs[i].unf);
    end

    // Fill with 17 writes: the 17th is dropped and flags overflow.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      cyc(1'b0, 1'b1, 32'h1040 + 32'(4 * i), 1'b0, 1'b0);
      if (i < 16) begin
        chk_all($sformatf("fill%0d", i), 5'(i + 1), 1'b0, (i == 15), (i >= 11), 32'h0, 1'b0, 1'b0);
      end else begin
        chk_all("fill_over", 5'd16, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
      end
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_all("clr_full", 5'd16, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);

    // Full + simultaneous read and write: accepted, no overflow.
    cyc(1'b0, 1'b1, 32'h10FC, 1'b1, 1'b0);
    chk_all("full_rw", 5'd16, 1'b0, 1'b1, 1'b1, 32'h1040, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("drain%0d.data", i), data, (i < 16) ? (32'h1040 + 32'(4 * i)) : 32'h10FC);
      chk($sformatf("drain%0d.count", i), 32'(count), 32'(16 - i));
    end
    chk("drain.empty", 32'(empty), 32'd1);
    chk("drain.ovf", 32'(ovf), 32'd0);

    // Wrap-around: fill phase then drain phase against a queue model.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    q.delete();
    exp_data = 32'h0;
    for (int k = 0; k < 40; k++) begin
      w = (k < 20) ? 1'b1 : (k % 2 == 0);
      r = (k < 20) ? (k % 4 == 3) : 1'b1;
      rok = r && (q.size() > 0);
      if (rok) begin
        exp_data = q.pop_front();
      end else if (r) begin
        exp_data = 32'h0;
      end
      if (w && (q.size() < 16 || rok)) begin
        q.push_back(32'h1000 + 32'(k));
      end
      cyc(1'b0, w, 32'h1000 + 32'(k), r, 1'b0);
      chk($sformatf("wrap%0d.data", k), data, exp_data);
      chk($sformatf("wrap%0d.count", k), 32'(count), 32'(q.size()));
      chk($sformatf("wrap%0d.afull", k), 32'(afull), 32'(q.size() >= 12));
      chk($sformatf("wrap%0d.empty", k), 32'(empty), 32'(q.size() == 0));
    end

    // Trace filter window: boundaries inclusive.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h0FFF, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h1000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h10FF, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h1100, 1'b0, 1'b0);
`ifdef TRACE_FILTER_EN
    chk("filt.count", 32'(count), 32'd2);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("filt.rd0", data, 32'h1000);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("filt.rd1", data, 32'h10FF);
`else
    chk("nofilt.count", 32'(count), 32'd4);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("nofilt.rd0", data, 32'h0FFF);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("nofilt.rd1", data, 32'h1000);
`endif

    // Reset mid-operation with five entries held and underflow set.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 32'h1090 + 32'(i), 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_all("pre_rst", 5'd5, 1'b0, 1'b0, 1'b0, 32'h1090, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 32'h10AA, 1'b1, 1'b0);
    chk_all("mid_rst", 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_all("post_rst", 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
